// File: rtl/vga_pkg.sv
// Shared VGA/framebuffer constants and the arbiter state type.
package vga_pkg;

  localparam int unsigned SCREEN_X   = 320;
  localparam int unsigned SCREEN_Y   = 240;
  localparam int unsigned FB_DEPTH   = SCREEN_X * SCREEN_Y;
  localparam int unsigned COLOR_BITS = 3;
  localparam int unsigned ADDR_BITS  = 17;

  typedef enum logic [1:0] {
    IDLE,
    LECTURA,
    ESCRITURA,
    ESPERA
  } state_e;

endpackage

// File: rtl/calculo_direccion.sv
// Pixel position to linear framebuffer address, plus the active-region flag
// (combinational) and a one-cycle registered copy of that flag.
module calculo_direccion
  import vga_pkg::*;
#(
  parameter int unsigned ScreenX  = SCREEN_X,
  parameter int unsigned ScreenY  = SCREEN_Y,
  parameter int unsigned AddrBits = ADDR_BITS
) (
  input  logic                i_clock,
  input  logic                i_reset,
  input  logic [9:0]          i_pos_x,
  input  logic [9:0]          i_pos_y,
  output logic [AddrBits-1:0] o_addr,
  output logic                o_active,
  output logic                o_active_q
);

  logic r_active;

  // Exact for every active pixel; off-screen positions may wrap, but those reads are discarded.
  assign o_addr   = AddrBits'(i_pos_y) * AddrBits'(ScreenX) + AddrBits'(i_pos_x);
  assign o_active = (32'(i_pos_x) < ScreenX) && (32'(i_pos_y) < ScreenY);

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_active <= 1'b0;
    end else begin
      r_active <= o_active;
    end
  end

  assign o_active_q = r_active;

endmodule

// File: rtl/arbitro_framebuffer.sv
// Single-port framebuffer arbiter: the display read runs every cycle and
// processor writes take only inactive slots, at most one every two cycles.
module arbitro_framebuffer
  import vga_pkg::*;
#(
  parameter int unsigned ColorBits = COLOR_BITS,
  parameter int unsigned screenX   = SCREEN_X,
  parameter int unsigned screenY   = SCREEN_Y,
  parameter int unsigned AddrBits  = ADDR_BITS
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [9:0]           posicionX,
  input  logic [9:0]           posicionY,
  output logic [ColorBits-1:0] readValueMemory,
  input  logic                 wrReq,
  input  logic [AddrBits-1:0]  wrAddr,
  input  logic [ColorBits-1:0] wrData,
  output logic                 wrAck,
  output logic                 wrError,
  output logic [15:0]          waitCount,
  output logic [AddrBits-1:0]  memAddr,
  output logic                 memWrEn,
  output logic [ColorBits-1:0] memWrData,
  input  logic [ColorBits-1:0] memRdData
);

  localparam int unsigned FbDepth = screenX * screenY;

  state_e                r_state;
  state_e                w_state_next;
  logic                  w_grant;
  logic                  w_wr_oob;

  logic [AddrBits-1:0]   w_disp_addr;
  logic                  w_active;
  logic                  w_active_q;
  logic                  r_active_d2;

  logic [AddrBits-1:0]   r_mem_addr;
  logic [AddrBits-1:0]   w_mem_addr_d;
  logic                  r_mem_wr_en;
  logic                  w_mem_wr_en_d;
  logic [ColorBits-1:0]  r_mem_wr_data;
  logic [ColorBits-1:0]  w_mem_wr_data_d;
  logic [ColorBits-1:0]  r_read_value;
  logic [ColorBits-1:0]  w_read_value_d;
  logic                  r_wr_ack;
  logic                  r_wr_error;
  logic                  w_wr_error_d;
  logic [15:0]           r_wait_count;
  logic [15:0]           w_wait_count_d;

  calculo_direccion #(
    .ScreenX  (screenX),
    .ScreenY  (screenY),
    .AddrBits (AddrBits)
  ) u_calculo_direccion (
    .i_clock    (clock),
    .i_reset    (reset),
    .i_pos_x    (posicionX),
    .i_pos_y    (posicionY),
    .o_addr     (w_disp_addr),
    .o_active   (w_active),
    .o_active_q (w_active_q)
  );

  assign w_wr_oob = 32'(wrAddr) >= FbDepth;

  // Outputs are registered together with the state, so they follow the next state.
  always_comb begin
    w_state_next = IDLE;
    w_grant      = 1'b0;
    unique case (r_state)
      ESCRITURA: w_state_next = ESPERA;
      IDLE, LECTURA, ESPERA: begin
        if (w_active) begin
          w_state_next = LECTURA;
        end else if (wrReq) begin
          w_state_next = ESCRITURA;
          w_grant      = 1'b1;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_comb begin
    w_mem_addr_d    = w_disp_addr;
    w_mem_wr_en_d   = 1'b0;
    w_mem_wr_data_d = r_mem_wr_data;
    w_wr_error_d    = r_wr_error;
    w_wait_count_d  = r_wait_count;
    if (w_grant) begin
      w_mem_addr_d    = wrAddr;
      w_mem_wr_en_d   = ~w_wr_oob;
      w_mem_wr_data_d = wrData;
      w_wr_error_d    = r_wr_error | w_wr_oob;
      w_wait_count_d  = '0;
    end else if (wrReq && (r_state != ESCRITURA) && (r_wait_count != 16'hFFFF)) begin
      // The request still high during its own ack cycle is not waiting.
      w_wait_count_d = r_wait_count + 16'd1;
    end
  end

  assign w_read_value_d = r_active_d2 ? memRdData : '0;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state       <= IDLE;
      r_active_d2   <= 1'b0;
      r_mem_addr    <= '0;
      r_mem_wr_en   <= 1'b0;
      r_mem_wr_data <= '0;
      r_read_value  <= '0;
      r_wr_ack      <= 1'b0;
      r_wr_error    <= 1'b0;
      r_wait_count  <= '0;
    end else begin
      r_state       <= w_state_next;
      r_active_d2   <= w_active_q;
      r_mem_addr    <= w_mem_addr_d;
      r_mem_wr_en   <= w_mem_wr_en_d;
      r_mem_wr_data <= w_mem_wr_data_d;
      r_read_value  <= w_read_value_d;
      r_wr_ack      <= w_grant;
      r_wr_error    <= w_wr_error_d;
      r_wait_count  <= w_wait_count_d;
    end
  end

  assign memAddr         = r_mem_addr;
  assign memWrEn         = r_mem_wr_en;
  assign memWrData       = r_mem_wr_data;
  assign readValueMemory = r_read_value;
  assign wrAck           = r_wr_ack;
  assign wrError         = r_wr_error;
  assign waitCount       = r_wait_count;

endmodule

// File: tb/tb_arbitro_framebuffer.sv
// Bench for arbitro_framebuffer: synchronous RAM model, directed vectors and a
// randomized partial frame sweep checked against a scoreboard framebuffer.
module tb_arbitro_framebuffer;

  localparam int SX = 320;
  localparam int SY = 240;
  localparam int FB = SX * SY;

  logic        clock = 1'b0;
  logic        reset;
  logic [9:0]  posicionX, posicionY;
  logic [2:0]  readValueMemory;
  logic        wrReq;
  logic [16:0] wrAddr;
  logic [2:0]  wrData;
  logic        wrAck, wrError;
  logic [15:0] waitCount;
  logic [16:0] memAddr;
  logic        memWrEn;
  logic [2:0]  memWrData;
  logic [2:0]  memRdData;

  always #5 clock = ~clock;

  arbitro_framebuffer dut (
    .clock           (clock),
    .reset           (reset),
    .posicionX       (posicionX),
    .posicionY       (posicionY),
    .readValueMemory (readValueMemory),
    .wrReq           (wrReq),
    .wrAddr          (wrAddr),
    .wrData          (wrData),
    .wrAck           (wrAck),
    .wrError         (wrError),
    .waitCount       (waitCount),
    .memAddr         (memAddr),
    .memWrEn         (memWrEn),
    .memWrData       (memWrData),
    .memRdData       (memRdData)
  );

  // Background content of the RAM; stored values are XOR-ed with it so the
  // all-zero initial array still reads back a varied image.
  function automatic logic [2:0] pat(input int a);
    return 3'((a * 7) + (a >> 5));
  endfunction

  bit   [2:0]  fb [0:131071];
  logic [16:0] bd_addr = '0;
  logic [2:0]  bd_data = '0;
  logic        bd_we = 1'b0;

  always @(posedge clock) begin
    if (memWrEn) fb[memAddr] <= memWrData ^ pat(int'(memAddr));
    else if (bd_we) fb[bd_addr] <= bd_data ^ pat(int'(bd_addr));
    memRdData <= fb[memAddr] ^ pat(int'(memAddr));
  end

  logic [2:0] ref_fb [0:FB-1];
  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic preload(input int a, input int v);
    bd_addr = 17'(a);
    bd_data = 3'(v);
    bd_we   = 1'b1;
    @(negedge clock);
    bd_we   = 1'b0;
    ref_fb[a] = 3'(v);
  endtask

  typedef struct {
    int x;
    int y;
    int preload;
    int exp_addr;  // -1: off-screen, address not checked
    int exp_rd;
  } vec_t;
  vec_t vecs [9];

  // Sweep scoreboard state
  logic [2:0] s_val [3];
  bit         s_vld [3];
  bit         prev_active, prev_ack, req_pending;
  int         prev_addr, req_addr, req_data, req_wait, n_writes;

  task automatic sweep_step(input int x, input int y);
    @(negedge clock);
    if (s_vld[2]) chk("sweep_rd", readValueMemory, s_val[2]);
    s_vld[2] = s_vld[1]; s_val[2] = s_val[1];
    s_vld[1] = s_vld[0]; s_val[1] = s_val[0];
    chk("sweep_no_wr_active", memWrEn & prev_active, 0);
    if (prev_active) chk("sweep_addr", memAddr, prev_addr);
    if (wrAck) begin
      chk("sweep_ack_spacing", prev_ack, 0);
      chk("sweep_ack_pending", req_pending, 1);
      chk("sweep_wr_addr", memAddr, req_addr);
      chk("sweep_wr_data", memWrData, req_data);
      chk("sweep_wr_en", memWrEn, 1);
      ref_fb[req_addr] = 3'(req_data);
      req_pending = 1'b0;
      wrReq = 1'b0;
      n_writes++;
    end else if (req_pending) begin
      req_wait++;
      if (req_wait == 701) chk("sweep_wait_bound", req_wait, 700);
    end
    prev_ack = wrAck;
    if (!req_pending && $urandom_range(0, 3) == 0) begin
      if ($urandom_range(0, 1) == 1) req_addr = int'($urandom_range(0, 4 * SX - 1));
      else req_addr = int'($urandom_range(236 * SX, FB - 1));
      req_data    = int'($urandom_range(0, 7));
      wrAddr      = 17'(req_addr);
      wrData      = 3'(req_data);
      wrReq       = 1'b1;
      req_pending = 1'b1;
      req_wait    = 0;
    end
    posicionX   = 10'(x);
    posicionY   = 10'(y);
    prev_active = (x < SX) && (y < SY);
    prev_addr   = y * SX + x;
    s_vld[0]    = 1'b1;
    s_val[0]    = prev_active ? ref_fb[prev_addr] : 3'd0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int ys [16] = '{236, 237, 238, 239, 240, 241, 242, 243, 476, 477, 478, 479, 0, 1, 2, 3};

    vecs[0] = '{5,   2,   5, 645,   5};
    vecs[1] = '{0,   0,   3, 0,     3};
    vecs[2] = '{319, 239, 6, 76799, 6};
    vecs[3] = '{319, 0,   1, 319,   1};
    vecs[4] = '{0,   1,   7, 320,   7};
    vecs[5] = '{100, 100, 2, 32100, 2};
    vecs[6] = '{320, 0,   4, -1,    0};
    vecs[7] = '{0,   240, 4, -1,    0};
    vecs[8] = '{639, 479, 4, -1,    0};

    for (int i = 0; i < FB; i++) ref_fb[i] = pat(i);

    reset = 1'b1; posicionX = 10'd400; posicionY = 10'd10;
    wrReq = 1'b0; wrAddr = '0; wrData = '0;
    repeat (3) @(negedge clock);
    chk("rst_memAddr", memAddr, 0);
    chk("rst_memWrEn", memWrEn, 0);
    chk("rst_memWrData", memWrData, 0);
    chk("rst_readValue", readValueMemory, 0);
    chk("rst_wrAck", wrAck, 0);
    chk("rst_wrError", wrError, 0);
    chk("rst_waitCount", waitCount, 0);

    // Reset held three cycles while an (out-of-range) write is in ESCRITURA
    reset = 1'b0; wrReq = 1'b1; wrAddr = 17'd76800; wrData = 3'd7;
    @(negedge clock);
    chk("pre_reset_ack", wrAck, 1);
    reset = 1'b1;
    repeat (3) @(negedge clock);
    chk("midrst_wrAck", wrAck, 0);
    chk("midrst_wrError", wrError, 0);
    chk("midrst_memWrEn", memWrEn, 0);
    chk("midrst_waitCount", waitCount, 0);
    reset = 1'b0; wrReq = 1'b0;
    @(negedge clock);
    chk("post_rst_no_ack", wrAck, 0);
    chk("post_rst_no_wr", memWrEn, 0);
    wrReq = 1'b1; wrAddr = 17'd50; wrData = 3'd1;
    @(negedge clock);
    chk("post_rst_grant", wrAck, 1);
    chk("post_rst_addr", memAddr, 50);
    ref_fb[50] = 3'd1;
    wrReq = 1'b0;
    @(negedge clock);

    // Table-driven display reads
    for (int i = 0; i < 9; i++) begin
      if (vecs[i].exp_addr >= 0) preload(vecs[i].exp_addr, vecs[i].preload);
      posicionX = 10'(vecs[i].x);
      posicionY = 10'(vecs[i].y);
      @(negedge clock);
      if (vecs[i].exp_addr >= 0) chk("vec_addr", memAddr, vecs[i].exp_addr);
      chk("vec_wren", memWrEn, 0);
      repeat (2) @(negedge clock);
      chk("vec_rd", readValueMemory, vecs[i].exp_rd);
    end

    // waitCount holds when the request is withdrawn
    posicionX = 10'd10; posicionY = 10'd10;
    wrReq = 1'b1; wrAddr = 17'd7; wrData = 3'd1;
    repeat (3) @(negedge clock);
    wrReq = 1'b0;
    repeat (2) @(negedge clock);
    chk("wait_hold", waitCount, 3);

    // Back-to-back requests outside the region
    posicionX = 10'd400; posicionY = 10'd10;
    wrReq = 1'b1; wrAddr = 17'd100; wrData = 3'd3;
    @(negedge clock);
    chk("wr1_ack", wrAck, 1);
    chk("wr1_en", memWrEn, 1);
    chk("wr1_addr", memAddr, 100);
    chk("wr1_data", memWrData, 3);
    chk("wr1_wait_clr", waitCount, 0);
    ref_fb[100] = 3'd3;
    wrAddr = 17'd101; wrData = 3'd6;
    @(negedge clock);
    chk("espera_no_ack", wrAck, 0);
    chk("espera_no_wr", memWrEn, 0);
    @(negedge clock);
    chk("wr2_ack", wrAck, 1);
    chk("wr2_addr", memAddr, 101);
    chk("wr2_data", memWrData, 6);
    ref_fb[101] = 3'd6;
    wrReq = 1'b0;
    @(negedge clock);

    // Request raised near the right edge of an active line
    posicionX = 10'd310; posicionY = 10'd10;
    wrReq = 1'b1; wrAddr = 17'd200; wrData = 3'd5;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      chk("edge_no_ack", wrAck, 0);
      chk("edge_wait", waitCount, i + 1);
      posicionX = 10'(311 + i);
    end
    @(negedge clock);
    chk("edge_ack", wrAck, 1);
    chk("edge_addr", memAddr, 200);
    chk("edge_wait_clr", waitCount, 0);
    ref_fb[200] = 3'd5;
    wrReq = 1'b0; posicionX = 10'd400;
    @(negedge clock);

    // Out-of-range write, then a legal one at the last pixel
    wrReq = 1'b1; wrAddr = 17'd76800; wrData = 3'd2;
    @(negedge clock);
    chk("oor_ack", wrAck, 1);
    chk("oor_no_wr", memWrEn, 0);
    chk("oor_err", wrError, 1);
    wrAddr = 17'd76799; wrData = 3'd4;
    @(negedge clock);
    chk("oor_err_hold1", wrError, 1);
    @(negedge clock);
    chk("last_ack", wrAck, 1);
    chk("last_en", memWrEn, 1);
    chk("last_addr", memAddr, 76799);
    chk("oor_err_hold2", wrError, 1);
    ref_fb[76799] = 3'd4;
    wrReq = 1'b0;
    @(negedge clock);

    // Partial frame sweep with random concurrent writes, including both wraps
    prev_active = 1'b0; prev_ack = 1'b0; req_pending = 1'b0; n_writes = 0;
    for (int k = 0; k < 3; k++) s_vld[k] = 1'b0;
    foreach (ys[j]) begin
      for (int x = 0; x < 640; x++) sweep_step(x, ys[j]);
    end
    repeat (3) sweep_step(400, 479);
    chk("sweep_writes_seen", n_writes > 0, 1);
    chk("sweep_err_sticky", wrError, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
